// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// legal WIDTH range checked at elaboration.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The ovf wire exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    // The producer/consumer side of the adder.
    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout, busy
    );

    // The adder side.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder; the only arithmetic element of the
// serial adder.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first, through fa_cell.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output bus.ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
            $error("serial_adder: WIDTH out of legal range");
        end
    endgenerate

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] s_sh_q;
    logic [WIDTH-1:0] s_sh_d;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] count_q;
    logic             carry_q;
    logic             cout_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             fa_s;
    logic             fa_co;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    fa_cell u_fa (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at bit 0.
    assign s_sh_d = {fa_s, s_sh_q[WIDTH-1:1]};

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            s_sh_q      <= '0;
            sum_q       <= '0;
            count_q     <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= bus.b;
                        carry_q <= bus.cin;
                        s_sh_q  <= '0;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    carry_q <= fa_co;
                    a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
                    s_sh_q  <= s_sh_d;
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == LAST_CNT) begin
                        sum_q       <= s_sh_d;
                        cout_q      <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry_q is the carry into the MSB on this final bit.
                        ovf_q       <= carry_q ^ fa_co;
`endif
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.busy      = busy_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder with WIDTH=8.
// Covers the overflow output when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   cyc     = 0;
    int   hs_cnt  = 0;
    int   errors  = 0;
    int   checks  = 0;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) hs_cnt <= hs_cnt + 1;

    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                          output int k, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.in_ready === 1'b1);
        bus.a        = av;
        bus.b        = bv;
        bus.cin      = ci;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int t, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.out_valid === 1'b1);
        t  = cyc;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl: got in_ready/out_valid/busy=%b want 100",
                     {bus.in_ready, bus.out_valid, bus.busy});
        end
        checks++;
        if ({bus.cout, bus.sum} !== 9'h000) begin
            errors++;
            $display("FAIL reset_data: got cout,sum=%h want 000", {bus.cout, bus.sum});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_carry_ripple;
        int k, t;
        bit ok;
        bus.out_ready = 1'b1;
        accept(8'hFF, 8'h01, 1'b0, k, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ripple_accept: in_ready never 1"); end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL ripple_run_flags: got busy/in_ready=%b want 10", {bus.busy, bus.in_ready});
        end
        wait_out(t, ok);
        checks++;
        if (!ok || (t - k) !== 8) begin
            errors++;
            $display("FAIL ripple_latency: got %0d cycles (ok=%0d) want 8", t - k, ok);
        end
        checks++;
        if ({bus.cout, bus.sum} !== 9'h100) begin
            errors++;
            $display("FAIL ripple_result: got cout,sum=%h want 100", {bus.cout, bus.sum});
        end
    endtask

    task automatic test_carry_chain;
        int k, t;
        bit ok;
        bus.out_ready = 1'b1;
        accept(8'h55, 8'hAA, 1'b1, k, ok);
        wait_out(t, ok);
        checks++;
        if (!ok || {bus.cout, bus.sum} !== 9'h100) begin
            errors++;
            $display("FAIL chain_result: got cout,sum=%h (ok=%0d) want 100", {bus.cout, bus.sum}, ok);
        end
        accept(8'h00, 8'h00, 1'b0, k, ok);
        wait_out(t, ok);
        checks++;
        if (!ok || {bus.cout, bus.sum} !== 9'h000) begin
            errors++;
            $display("FAIL zero_result: got cout,sum=%h (ok=%0d) want 000", {bus.cout, bus.sum}, ok);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_in_ready: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL post_handshake: got in_ready/out_valid=%b want 10", {bus.in_ready, bus.out_valid});
        end
    endtask

    task automatic test_backpressure;
        int k, t, bad;
        bit ok;
        bus.out_ready = 1'b0;
        accept(8'h3C, 8'h0F, 1'b0, k, ok);
        wait_out(t, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_valid: out_valid never rose"); end
        bus.a = 8'h11; bus.b = 8'h22; bus.cin = 1'b1; bus.in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.cout, bus.sum} !== {2'b10, 9'h04B}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid/ready=%b cout,sum=%h want 10 04B",
                         i, {bus.out_valid, bus.in_ready}, {bus.cout, bus.sum});
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_no_accept: out_valid seen %0d cycles after release want 0", bad);
        end
    endtask

    task automatic test_reset_mid;
        int k, t;
        bit ok;
        bus.out_ready = 1'b1;
        accept(8'hF0, 8'h10, 1'b0, k, ok);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001 || bus.sum !== 8'h00) begin
            errors++;
            $display("FAIL midrst_state: got valid/busy/ready=%b sum=%h want 001 00",
                     {bus.out_valid, bus.busy, bus.in_ready}, bus.sum);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL midrst_release: got ready/valid=%b want 10", {bus.in_ready, bus.out_valid});
        end
        accept(8'h01, 8'h02, 1'b0, k, ok);
        wait_out(t, ok);
        checks++;
        if (!ok || {bus.cout, bus.sum} !== 9'h003) begin
            errors++;
            $display("FAIL midrst_fresh: got cout,sum=%h (ok=%0d) want 003", {bus.cout, bus.sum}, ok);
        end
    endtask

    task automatic test_back_to_back;
        int k, t, k_first, hs0, bad;
        bit ok, ok2;
        logic [8:0] exp;
        bus.out_ready = 1'b1;
        bad     = 0;
        k_first = 0;
        k       = 0;
        @(negedge clk);
        hs0 = hs_cnt;
        for (int ci = 0; ci < 2; ci++) begin
            for (int av = 0; av < 16; av++) begin
                for (int bv = 0; bv < 16; bv++) begin
                    exp = 9'(av + bv + ci);
                    accept(8'(av), 8'(bv), 1'(ci), k, ok);
                    if (ci == 0 && av == 0 && bv == 0) k_first = k;
                    wait_out(t, ok2);
                    checks++;
                    if (!ok || !ok2 || {bus.cout, bus.sum} !== exp) begin
                        errors++;
                        bad++;
                        if (bad < 10)
                            $display("FAIL nibble a=%0d b=%0d cin=%0d: got cout,sum=%h want %h",
                                     av, bv, ci, {bus.cout, bus.sum}, exp);
                    end
                end
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (hs_cnt - hs0 !== 512) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want 512", hs_cnt - hs0);
        end
        checks++;
        if (k - k_first !== 511 * 10) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d cycles want %0d", k - k_first, 511 * 10);
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf;
        int k, t;
        bit ok;
        bus.out_ready = 1'b1;
        accept(8'h7F, 8'h01, 1'b0, k, ok);
        wait_out(t, ok);
        checks++;
        if (!ok || {bus.ovf, bus.cout, bus.sum} !== 10'h280) begin
            errors++;
            $display("FAIL ovf_pos: got ovf=%b cout=%b sum=%h want 1 0 80", bus.ovf, bus.cout, bus.sum);
        end
        accept(8'hFF, 8'h01, 1'b0, k, ok);
        wait_out(t, ok);
        checks++;
        if (!ok || {bus.ovf, bus.cout, bus.sum} !== 10'h100) begin
            errors++;
            $display("FAIL ovf_wrap: got ovf=%b cout=%b sum=%h want 0 1 00", bus.ovf, bus.cout, bus.sum);
        end
    endtask
`endif

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_carry_ripple();
        test_carry_chain();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
